tag_way_scan_ctrl: RTL and testbench

- Lookup/replacement controller for the 4-way set-associative tag bank.
- Sequences the bank's 4:1 way mux, driving the way select one way per cycle and comparing the returned tag and valid bit against the request.
- On a hit, reports the way. On a miss, picks a victim (first invalid way, else tree pseudo-LRU), handshakes a line fill, then writes the new tag.
- Sits between the cache front-end and the tag bank/way mux.

---
 rtl/tag_way_scan_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_tag_way_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_way_scan_ctrl.sv
// Lookup/replacement controller for a 4-way set-associative tag bank: scans ways
// one per cycle, fills on miss with tree-PLRU victim. Optional counters: TAG_SCAN_STATS_EN.
module tag_way_scan_ctrl #(
    parameter int TAG_W    = 20,
    parameter int SET_BITS = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic [SET_BITS-1:0] REQ_SET,
    input  logic [TAG_W-1:0]    REQ_TAG,
    output logic [SET_BITS-1:0] TAG_SET,
    output logic [1:0]          WAY_SEL,
    input  logic [TAG_W-1:0]    TAG_IN,
    input  logic                VALID_IN,
    output logic                FILL_REQ,
    input  logic                FILL_ACK,
    output logic                TAG_WE,
    output logic [TAG_W-1:0]    TAG_WDATA,
    output logic                RESP_VALID,
    output logic                RESP_HIT,
    output logic [1:0]          RESP_WAY
`ifdef TAG_SCAN_STATS_EN
    ,
    output logic [15:0]         HIT_CNT,
    output logic [15:0]         MISS_CNT
`endif
);

    localparam int NSETS = 1 << SET_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FILL,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [1:0]          way_sel_q, way_sel_d;
    logic                inv_found_q, inv_found_d;
    logic [1:0]          inv_way_q, inv_way_d;
    logic [TAG_W-1:0]    wdata_q, wdata_d;
    logic                resp_hit_q, resp_hit_d;
    logic [1:0]          resp_way_q, resp_way_d;
    logic [2:0]          plru_q [NSETS];
    logic [2:0]          plru_row_d;
    logic                plru_we;

    logic                hit;
    logic                inv_now;
    logic [1:0]          inv_now_way;

    // Tree update: root points away from the touched half, leaf away from the touched way.
    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] w);
        logic [2:0] r;
        r    = bits;
        r[0] = ~w[1];
        if (!w[1]) r[1] = ~w[0];
        else       r[2] = ~w[0];
        return r;
    endfunction

    function automatic logic [1:0] plru_victim(input logic [2:0] bits);
        return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    endfunction

    assign hit = VALID_IN && (TAG_IN == tag_q);

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        tag_d       = tag_q;
        way_sel_d   = way_sel_q;
        inv_found_d = inv_found_q;
        inv_way_d   = inv_way_q;
        wdata_d     = wdata_q;
        resp_hit_d  = resp_hit_q;
        resp_way_d  = resp_way_q;
        plru_we     = 1'b0;
        plru_row_d  = plru_touch(plru_q[set_q], way_sel_q);
        inv_now     = inv_found_q;
        inv_now_way = inv_way_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    set_d       = REQ_SET;
                    tag_d       = REQ_TAG;
                    way_sel_d   = 2'd0;
                    inv_found_d = 1'b0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (hit) begin
                    resp_hit_d = 1'b1;
                    resp_way_d = way_sel_q;
                    plru_we    = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    // The way being looked at this cycle can itself be the first invalid one.
                    if (!VALID_IN && !inv_found_q) begin
                        inv_found_d = 1'b1;
                        inv_way_d   = way_sel_q;
                        inv_now     = 1'b1;
                        inv_now_way = way_sel_q;
                    end
                    if (way_sel_q == 2'd3) begin
                        way_sel_d = inv_now ? inv_now_way : plru_victim(plru_q[set_q]);
                        state_d   = ST_FILL;
                    end else begin
                        way_sel_d = way_sel_q + 2'd1;
                    end
                end
            end
            ST_FILL: begin
                if (FILL_ACK) begin
                    wdata_d = tag_q;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                plru_we    = 1'b1;
                resp_hit_d = 1'b0;
                resp_way_d = way_sel_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            set_q       <= '0;
            tag_q       <= '0;
            way_sel_q   <= 2'd0;
            inv_found_q <= 1'b0;
            inv_way_q   <= 2'd0;
            wdata_q     <= '0;
            resp_hit_q  <= 1'b0;
            resp_way_q  <= 2'd0;
            for (int i = 0; i < NSETS; i++) plru_q[i] <= 3'b000;
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            tag_q       <= tag_d;
            way_sel_q   <= way_sel_d;
            inv_found_q <= inv_found_d;
            inv_way_q   <= inv_way_d;
            wdata_q     <= wdata_d;
            resp_hit_q  <= resp_hit_d;
            resp_way_q  <= resp_way_d;
            if (plru_we) plru_q[set_q] <= plru_row_d;
        end
    end

    assign REQ_READY  = (state_q == ST_IDLE);
    assign FILL_REQ   = (state_q == ST_FILL);
    assign TAG_WE     = (state_q == ST_WRITE);
    assign RESP_VALID = (state_q == ST_RESP);
    assign TAG_SET    = set_q;
    assign WAY_SEL    = way_sel_q;
    assign TAG_WDATA  = wdata_q;
    assign RESP_HIT   = resp_hit_q;
    assign RESP_WAY   = resp_way_q;

`ifdef TAG_SCAN_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_RESP) begin
            if (resp_hit_q && hit_cnt_q != 16'hFFFF)    hit_cnt_d  = hit_cnt_q + 16'd1;
            if (!resp_hit_q && miss_cnt_q != 16'hFFFF)  miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign HIT_CNT  = hit_cnt_q;
    assign MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tag_way_scan_ctrl.sv
// Self-checking bench for tag_way_scan_ctrl: bank model driven by the bench,
// expected hit/victim/latency derived from the lookup and PLRU rules.
module tb_tag_way_scan_ctrl;

    localparam int TAG_W    = 20;
    localparam int SET_BITS = 4;
    localparam int NSETS    = 1 << SET_BITS;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                REQ_VALID = 1'b0;
    logic                REQ_READY;
    logic [SET_BITS-1:0] REQ_SET = '0;
    logic [TAG_W-1:0]    REQ_TAG = '0;
    logic [SET_BITS-1:0] TAG_SET;
    logic [1:0]          WAY_SEL;
    logic [TAG_W-1:0]    TAG_IN;
    logic                VALID_IN;
    logic                FILL_REQ;
    logic                FILL_ACK = 1'b0;
    logic                TAG_WE;
    logic [TAG_W-1:0]    TAG_WDATA;
    logic                RESP_VALID;
    logic                RESP_HIT;
    logic [1:0]          RESP_WAY;
`ifdef TAG_SCAN_STATS_EN
    logic [15:0]         HIT_CNT;
    logic [15:0]         MISS_CNT;
`endif

    tag_way_scan_ctrl #(.TAG_W(TAG_W), .SET_BITS(SET_BITS)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_SET(REQ_SET), .REQ_TAG(REQ_TAG),
        .TAG_SET(TAG_SET), .WAY_SEL(WAY_SEL),
        .TAG_IN(TAG_IN), .VALID_IN(VALID_IN),
        .FILL_REQ(FILL_REQ), .FILL_ACK(FILL_ACK),
        .TAG_WE(TAG_WE), .TAG_WDATA(TAG_WDATA),
        .RESP_VALID(RESP_VALID), .RESP_HIT(RESP_HIT), .RESP_WAY(RESP_WAY)
`ifdef TAG_SCAN_STATS_EN
        , .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    logic [TAG_W-1:0] bank_tag [NSETS][4];
    logic             bank_vld [NSETS][4];
    assign TAG_IN   = bank_tag[TAG_SET][WAY_SEL];
    assign VALID_IN = bank_vld[TAG_SET][WAY_SEL];

    // Reference replacement state: per set, root says which half is older, leaves which way.
    logic [2:0] m_plru [NSETS];
    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int ref_victim(input logic [2:0] b);
        int older_half;
        older_half = b[0] ? 1 : 0;
        return older_half * 2 + (older_half == 1 ? int'(b[2]) : int'(b[1]));
    endfunction

    function automatic logic [2:0] ref_touch(input logic [2:0] b, input int w);
        logic [2:0] r;
        r    = b;
        r[0] = (w < 2);
        if (w < 2) r[1] = (w == 0);
        else       r[2] = (w == 2);
        return r;
    endfunction

    task automatic check_reset_state(input string name);
        check({name, "_ready"}, REQ_READY, 1);
        check({name, "_fill"}, FILL_REQ, 0);
        check({name, "_we"}, TAG_WE, 0);
        check({name, "_rv"}, RESP_VALID, 0);
        check({name, "_waysel"}, WAY_SEL, 0);
        check({name, "_tagset"}, TAG_SET, 0);
        check({name, "_wdata"}, TAG_WDATA, 0);
        check({name, "_hit"}, RESP_HIT, 0);
        check({name, "_way"}, RESP_WAY, 0);
`ifdef TAG_SCAN_STATS_EN
        check({name, "_hitcnt"}, HIT_CNT, 0);
        check({name, "_misscnt"}, MISS_CNT, 0);
`endif
    endtask

    // Runs one lookup from a negedge in (or waiting for) IDLE; ends at the negedge of the IDLE cycle after RESP.
    task automatic do_req(input logic [SET_BITS-1:0] s, input logic [TAG_W-1:0] t,
                          input int ack_wait, input int rst_at, input bit hold,
                          input logic [SET_BITS-1:0] s2, input logic [TAG_W-1:0] t2);
        int  n;
        bit  exp_hit;
        bit  found;
        int  exp_way;
        int  nscan;
        int  f;
        int  resp_c;
        n = 0;
        while (!REQ_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("req_ready_wait", REQ_READY, 1);

        exp_hit = 0;
        exp_way = 0;
        for (int w = 0; w < 4; w++)
            if (!exp_hit && bank_vld[s][w] && bank_tag[s][w] == t) begin
                exp_hit = 1;
                exp_way = w;
            end
        if (!exp_hit) begin
            found = 0;
            for (int w = 0; w < 4; w++)
                if (!found && !bank_vld[s][w]) begin
                    found   = 1;
                    exp_way = w;
                end
            if (!found) exp_way = ref_victim(m_plru[s]);
        end
        nscan  = exp_hit ? exp_way + 1 : 4;
        f      = 5 + ack_wait;
        resp_c = exp_hit ? exp_way + 2 : f + 2;

        REQ_VALID = 1'b1;
        REQ_SET   = s;
        REQ_TAG   = t;
        @(posedge CLK);
        #1;
        if (hold) begin
            REQ_SET = s2;
            REQ_TAG = t2;
        end else begin
            REQ_VALID = 1'b0;
            REQ_SET   = SET_BITS'($urandom);
            REQ_TAG   = TAG_W'($urandom);
        end

        for (int c = 1; c <= resp_c; c++) begin
            @(negedge CLK);
            check("busy_ready", REQ_READY, 0);
            check("tag_set", TAG_SET, s);
            if (c <= nscan) check("scan_way", WAY_SEL, c - 1);
            check("fill_req", FILL_REQ, !exp_hit && c >= 5 && c <= f);
            check("tag_we", TAG_WE, !exp_hit && c == f + 1);
            check("resp_valid", RESP_VALID, c == resp_c);
            if (TAG_WE) begin
                check("we_way", WAY_SEL, exp_way);
                check("we_data", TAG_WDATA, t);
                bank_tag[TAG_SET][WAY_SEL] = TAG_WDATA;
                bank_vld[TAG_SET][WAY_SEL] = 1'b1;
            end
            if (c == resp_c) begin
                check("resp_hit", RESP_HIT, exp_hit);
                check("resp_way", RESP_WAY, exp_way);
            end
            if (c >= 5 && c <= f && !exp_hit) FILL_ACK = (c == f);
            else FILL_ACK = 1'($urandom_range(0, 1));
            if (c == rst_at) begin
                FILL_ACK = 1'b0;
                RST      = 1'b1;
                @(posedge CLK);
                #1;
                RST = 1'b0;
                REQ_VALID = 1'b0;
                for (int i = 0; i < NSETS; i++) m_plru[i] = 3'b000;
                exp_hits   = 0;
                exp_misses = 0;
                @(negedge CLK);
                check_reset_state("abort");
                return;
            end
        end

        m_plru[s] = ref_touch(m_plru[s], exp_way);
        if (exp_hit) exp_hits++;
        else exp_misses++;
        @(negedge CLK);
        check("idle_ready", REQ_READY, 1);
        check("idle_rv", RESP_VALID, 0);
        check("hold_hit", RESP_HIT, exp_hit);
        check("hold_way", RESP_WAY, exp_way);
`ifdef TAG_SCAN_STATS_EN
        check("hit_cnt", HIT_CNT, exp_hits);
        check("miss_cnt", MISS_CNT, exp_misses);
`endif
    endtask

    initial begin
        for (int i = 0; i < NSETS; i++) begin
            m_plru[i] = 3'b000;
            for (int w = 0; w < 4; w++) begin
                bank_tag[i][w] = '0;
                bank_vld[i][w] = 1'b0;
            end
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_reset_state("reset");

        // All-invalid set: first invalid way (0) is filled after the ack in cycle 7.
        do_req(4'd3, 20'h12345, 2, 0, 0, '0, '0);

        // Set 2: matching tag sits in way 2, others valid with other tags.
        for (int w = 0; w < 4; w++) begin
            bank_vld[2][w] = 1'b1;
            bank_tag[2][w] = 20'h22000 + TAG_W'(w);
        end
        do_req(4'd2, 20'h22002, 0, 0, 0, '0, '0);

        // Set 5 all valid: hit each way, then misses walk the PLRU tree.
        for (int w = 0; w < 4; w++) begin
            bank_vld[5][w] = 1'b1;
            bank_tag[5][w] = 20'h55000 + TAG_W'(w);
        end
        for (int w = 0; w < 4; w++) do_req(4'd5, 20'h55000 + TAG_W'(w), 0, 0, 0, '0, '0);
        do_req(4'd5, 20'h5AAAA, 0, 0, 0, '0, '0);
        do_req(4'd5, 20'h5AAAA, 0, 0, 0, '0, '0);
        do_req(4'd5, 20'h5BBBB, 1, 0, 0, '0, '0);

        // Set 1: ways 1 and 3 invalid, so way 1 is the victim.
        bank_vld[1][0] = 1'b1; bank_tag[1][0] = 20'h11110;
        bank_vld[1][2] = 1'b1; bank_tag[1][2] = 20'h11112;
        do_req(4'd1, 20'h1FFFF, 0, 0, 0, '0, '0);

        // Set 6: skew the PLRU, abort a miss mid-fill, then a miss must pick way 0.
        for (int w = 0; w < 4; w++) begin
            bank_vld[6][w] = 1'b1;
            bank_tag[6][w] = 20'h66000 + TAG_W'(w);
        end
        do_req(4'd6, 20'h66000, 0, 0, 0, '0, '0);
        do_req(4'd6, 20'h6DEAD, 3, 6, 0, '0, '0);
        do_req(4'd6, 20'h6BEEF, 0, 0, 0, '0, '0);

        // Request held high during a lookup is served only after the first response.
        do_req(4'd2, 20'h22001, 0, 0, 1, 4'd5, 20'h55001);
        do_req(4'd5, 20'h55001, 0, 0, 0, '0, '0);

        // Random traffic over a few sets with a small tag pool so hits and misses mix.
        for (int i = 8; i < 12; i++)
            for (int w = 0; w < 4; w++) begin
                bank_vld[i][w] = 1'($urandom_range(0, 1));
                bank_tag[i][w] = 20'hA0000 + TAG_W'($urandom_range(0, 5));
            end
        for (int k = 0; k < 40; k++)
            do_req(SET_BITS'($urandom_range(8, 11)), 20'hA0000 + TAG_W'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), 0, 0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=done", checks);
        $fatal(1);
    end

endmodule
